// File: rtl/fastica_fx_pkg.sv
// Shared fixed-point helpers and FSM encoding for the FastICA outer-product engine.
package fastica_fx_pkg;

  localparam int FX_W  = 26;
  localparam int FX_F  = 13;
  localparam int FX_PW = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Scale a sign-extended product: optional half-up rounding, arithmetic shift by f,
  // then clamp to a w-bit signed range when sat is set (caller keeps the low w bits).
  function automatic logic signed [FX_PW-1:0] fx_scale(
    input logic signed [FX_PW-1:0] p,
    input int                      w,
    input int                      f,
    input logic                    rnd,
    input logic                    sat
  );
    logic signed [FX_PW-1:0] r;
    logic signed [FX_PW-1:0] s;
    logic signed [FX_PW-1:0] hi;
    logic signed [FX_PW-1:0] lo;
    r = p;
    if (rnd && (f > 0))
      r = p + ({{(FX_PW-1){1'b0}}, 1'b1} << (f - 1));
    s  = r >>> f;
    hi = ({{(FX_PW-1){1'b0}}, 1'b1} << (w - 1)) - 1;
    lo = ~hi;
    if (sat) begin
      if (s > hi)
        s = hi;
      else if (s < lo)
        s = lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/fx_mul_lane.sv
// One signed multiplier lane: raw product register followed by the scaled output register.
module fx_mul_lane
  import fastica_fx_pkg::*;
#(
  parameter int W = FX_W,
  parameter int F = FX_F
) (
  input  logic                clk_mul,
  input  logic                rst_mul,
  input  logic                adv,
  input  logic                rnd,
  input  logic                sat,
  input  logic signed [W-1:0] z,
  input  logic signed [W-1:0] w,
  output logic signed [W-1:0] y
);

  logic signed [2*W-1:0]   prod_p1;
  logic signed [FX_PW-1:0] prod_ext;
  logic signed [FX_PW-1:0] scaled;

  // Stage 1: full-precision product
  always_ff @(posedge clk_mul) begin
    if (adv)
      prod_p1 <= z * w;
  end

  assign prod_ext = {{(FX_PW-2*W){prod_p1[2*W-1]}}, prod_p1};
  assign scaled   = fx_scale(prod_ext, W, F, rnd, sat);

  // Stage 2: rounded / saturated result
  always_ff @(posedge clk_mul or posedge rst_mul) begin
    if (rst_mul)
      y <= '0;
    else if (adv)
      y <= scaled[W-1:0];
  end

endmodule

// File: rtl/fastica_outer_mul_seq.sv
// Streams z * w_m^T column by column through N shared multiplier lanes, m-major / k-minor,
// with a two-stage valid/ready pipeline that freezes as a whole on output backpressure.
module fastica_outer_mul_seq
  import fastica_fx_pkg::*;
#(
  parameter int W = FX_W,
  parameter int F = FX_F,
  parameter int N = 4,
  parameter int M = 4,
  localparam int UW = (M > 1) ? $clog2(M) : 1,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_mul,
  input  logic             rst_mul,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode_round,
  input  logic             mode_sat,
  input  logic [N*W-1:0]   z_in,
  input  logic [M*N*W-1:0] w_in,
  output logic [N*W-1:0]   z_hold,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [UW-1:0]    out_unit,
  output logic [CW-1:0]    out_col,
  output logic             out_last,
  output logic [N*W-1:0]   out_data,
  output logic             busy
);

  localparam logic [UW-1:0] M_LAST = UW'(M - 1);
  localparam logic [CW-1:0] N_LAST = CW'(N - 1);

  state_t              state;
  logic                rnd_q;
  logic                sat_q;
  logic [UW-1:0]       m_q;
  logic [CW-1:0]       k_q;
  logic signed [W-1:0] w_lat [M*N];
  logic signed [W-1:0] w_sel;
  logic                adv;
  logic                last_issue;

  logic                vld_p1;
  logic                last_p1;
  logic [UW-1:0]       unit_p1;
  logic [CW-1:0]       col_p1;
  logic                vld_p2;
  logic                last_p2;
  logic [UW-1:0]       unit_p2;
  logic [CW-1:0]       col_p2;

  assign adv        = !vld_p2 || out_ready;
  assign last_issue = (m_q == M_LAST) && (k_q == N_LAST);

  always_comb begin
    w_sel = '0;
    for (int j = 0; j < M*N; j++)
      if (j == int'(m_q) * N + int'(k_q))
        w_sel = w_lat[j];
  end

  always_ff @(posedge clk_mul) begin
    if ((state == IDLE) && in_valid)
      for (int j = 0; j < M*N; j++)
        w_lat[j] <= w_in[j*W +: W];
  end

  always_ff @(posedge clk_mul or posedge rst_mul) begin
    if (rst_mul) begin
      state  <= IDLE;
      m_q    <= '0;
      k_q    <= '0;
      rnd_q  <= 1'b0;
      sat_q  <= 1'b0;
      z_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            z_hold <= z_in;
            rnd_q  <= mode_round;
            sat_q  <= mode_sat;
            m_q    <= '0;
            k_q    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (adv) begin
            if (k_q == N_LAST) begin
              k_q <= '0;
              m_q <= m_q + 1'b1;
            end else begin
              k_q <= k_q + 1'b1;
            end
            if (last_issue)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (vld_p2 && out_ready && last_p2)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 / stage 2 tag pipeline, moving in lockstep with the lanes
  always_ff @(posedge clk_mul or posedge rst_mul) begin
    if (rst_mul) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      unit_p1 <= '0;
      col_p1  <= '0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      unit_p2 <= '0;
      col_p2  <= '0;
    end else if (adv) begin
      vld_p1  <= (state == RUN);
      last_p1 <= (state == RUN) && last_issue;
      unit_p1 <= m_q;
      col_p1  <= k_q;
      vld_p2  <= vld_p1;
      last_p2 <= vld_p1 && last_p1;
      unit_p2 <= unit_p1;
      col_p2  <= col_p1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    fx_mul_lane #(.W(W), .F(F)) u_lane (
      .clk_mul (clk_mul),
      .rst_mul (rst_mul),
      .adv     (adv),
      .rnd     (rnd_q),
      .sat     (sat_q),
      .z       (z_hold[i*W +: W]),
      .w       (w_sel),
      .y       (out_data[i*W +: W])
    );
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = vld_p2;
  assign out_last  = last_p2;
  assign out_unit  = unit_p2;
  assign out_col   = col_p2;

endmodule
